mul_unit_pipelined: RTL and testbench

//  Parametrised RISC-V M-extension multiply unit (MUL/MULH/MULHSU/MULHU) for an XLEN-wide core.

---
 rtl/mul_unit_pipelined_if.sv | 31 +++
 rtl/mul_unit_pipelined.sv | 187 ++++++++++++++++++
 tb/tb_mul_unit_pipelined.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_unit_pipelined_if.sv
// Request/response bundle for the pipelined RISC-V M-extension multiplier.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high. The sender holds its payload stable while valid is high and
// ready is low; the receiver may change ready at any time. in_* carries
// requests into the unit, out_* carries results out of it.
interface mul_unit_pipelined_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      funct3;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    // Requester side (execute stage issuing the op and consuming the result)
    modport master (
        output in_valid, funct3, a, b, out_ready,
        input  in_ready, out_valid, result, busy
    );

    // Multiplier side
    modport slave (
        input  in_valid, funct3, a, b, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/mul_unit_pipelined.sv
// mul_unit_pipelined: MUL/MULH/MULHSU/MULHU unit with a programmable latency,
// flush support and an optional operand cache.
//
// Build option: define MUL_OPCACHE_EN to keep the last completed product so
// a repeat of the same operands (e.g. MULH followed by MUL) finishes one
// cycle after accept. Without it every op takes LATENCY cycles.
module mul_unit_pipelined #(
    parameter int XLEN    = 32,
    parameter int LATENCY = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    mul_unit_pipelined_if.slave  bus,
    output logic [1:0]           state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);

    state_t          state;
    logic [2:0]      count;
    logic [2:0]      op_f3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            op_hit;
    logic            in_ready_q;
    logic            out_valid_q;
    logic            busy_q;
    logic [XLEN-1:0] result_q;

    logic              hit;
    logic [2*XLEN-1:0] stage_p;
    logic [2*XLEN-1:0] final_p;
    logic [XLEN-1:0]   slice;

    // Signedness class: 0 = signed x signed, 1 = signed x unsigned, 2 = unsigned x unsigned
    function automatic logic [1:0] sign_class(input logic [2:0] f3);
        case (f3)
            3'b010:  return 2'd1;
            3'b011:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    // Stage 0: extend the latched operands to 2*XLEN and multiply. Only the
    // low 2*XLEN bits of the product are needed, so plain modular
    // multiplication of the extended operands gives the signed/unsigned product.
    logic              ext_a;
    logic              ext_b;
    logic [2*XLEN-1:0] a_wide;
    logic [2*XLEN-1:0] b_wide;
    logic [2*XLEN-1:0] prod;

    assign ext_a  = (op_f3 != 3'b011) & op_a[XLEN-1];
    assign ext_b  = (op_f3[2:1] == 2'b00) & op_b[XLEN-1];
    assign a_wide = {{XLEN{ext_a}}, op_a};
    assign b_wide = {{XLEN{ext_b}}, op_b};
    assign prod   = a_wide * b_wide;

    // Retiming stages after the multiply; operands stay stable while an op is
    // in flight so the chain needs no enable.
    generate
        if (LATENCY == 1) begin : g_no_pipe
            assign stage_p = prod;
        end else begin : g_pipe
            logic [2*XLEN-1:0] pipe [LATENCY-1];
            // Shift the product down the retiming chain every cycle
            always_ff @(posedge clk) begin
                pipe[0] <= prod;
                for (int i = 1; i < LATENCY - 1; i++) begin
                    pipe[i] <= pipe[i-1];
                end
            end
            assign stage_p = pipe[LATENCY-2];
        end
    endgenerate

`ifdef MUL_OPCACHE_EN
    logic              cache_valid;
    logic [XLEN-1:0]   cache_a;
    logic [XLEN-1:0]   cache_b;
    logic [1:0]        cache_cls;
    logic [2*XLEN-1:0] cache_p;

    // The low half is signedness-independent, so MUL hits on any class.
    assign hit = cache_valid && (bus.a == cache_a) && (bus.b == cache_b) &&
                 !bus.funct3[2] &&
                 ((bus.funct3 == 3'b000) || (sign_class(bus.funct3) == cache_cls));
    assign final_p = op_hit ? cache_p : stage_p;

    // Fill on every completed legal miss; drop the entry on reset or flush
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            cache_valid <= 1'b0;
        end else if (state == S_BUSY && count == 3'd0 && !op_hit && !op_f3[2]) begin
            cache_valid <= 1'b1;
            cache_a     <= op_a;
            cache_b     <= op_b;
            cache_cls   <= sign_class(op_f3);
            cache_p     <= stage_p;
        end
    end
`else
    assign hit     = 1'b0;
    assign final_p = stage_p;
`endif

    // Pick the architectural slice; reserved funct3 values produce zero
    always_comb begin
        slice = '0;
        case (op_f3)
            3'b000:                 slice = final_p[XLEN-1:0];
            3'b001, 3'b010, 3'b011: slice = final_p[2*XLEN-1:XLEN];
            default:                slice = '0;
        endcase
    end

    // Control FSM with registered handshake outputs; a hit runs as a
    // one-cycle BUSY so every op reaches DONE through the same path.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            count       <= 3'd0;
            op_f3       <= 3'b000;
            op_a        <= '0;
            op_b        <= '0;
            op_hit      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            result_q    <= '0;
        end else if (flush) begin
            state       <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        op_f3      <= bus.funct3;
                        op_a       <= bus.a;
                        op_b       <= bus.b;
                        op_hit     <= hit;
                        count      <= hit ? 3'd0 : CNT_INIT;
                        state      <= S_BUSY;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                S_BUSY: begin
                    if (count == 3'd0) begin
                        result_q    <= slice;
                        out_valid_q <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        count <= count - 3'd1;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        state       <= S_IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.result    = result_q;
    assign state_dbg     = state;

endmodule

// File: tb/tb_mul_unit_pipelined.sv
// Testbench for mul_unit_pipelined (XLEN=32, LATENCY=3): directed cases for
// reset, signedness, stall, flush, reset-in-flight, cache reuse and reserved
// funct3, followed by randomized ops checked against a reference model.
module tb_mul_unit_pipelined;

    localparam int XLEN    = 32;
    localparam int LATENCY = 3;

    logic       clk;
    logic       reset;
    logic       flush;
    logic [1:0] state_dbg;

    mul_unit_pipelined_if #(.XLEN(XLEN)) bus ();

    mul_unit_pipelined #(.XLEN(XLEN), .LATENCY(LATENCY)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .bus       (bus.slave),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [XLEN-1:0] exp_q[$];

    // reference cache model: last completed legal miss
    logic            mc_valid = 1'b0;
    logic [XLEN-1:0] mc_a;
    logic [XLEN-1:0] mc_b;
    int              mc_cls;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [XLEN-1:0] ref_mul(input logic [2:0] f3,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
        longint          sa;
        longint          sb;
        longint          ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        case (f3)
            3'd0: begin p = 64'(sa * sb); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'({32'b0, a}) * 64'({32'b0, b}); return p[63:32]; end
            default: return '0;
        endcase
    endfunction

    function automatic int cls_of(input logic [2:0] f3);
        if (f3 == 3'd2) return 1;
        if (f3 == 3'd3) return 2;
        return 0;
    endfunction

    function automatic bit model_hit(input logic [2:0] f3, input logic [XLEN-1:0] a,
                                     input logic [XLEN-1:0] b);
`ifdef MUL_OPCACHE_EN
        return mc_valid && a == mc_a && b == mc_b && f3 < 3'd4 &&
               (f3 == 3'd0 || cls_of(f3) == mc_cls);
`else
        return 1'b0;
`endif
    endfunction

    // ---------------- driver ----------------
    // Issue one op, check latency and result, optionally stall the consumer
    // while offering junk requests that must be ignored, then complete.
    task automatic do_op(input logic [2:0] f3, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input int stall,
                         output logic [XLEN-1:0] got);
        logic [XLEN-1:0] e;
        int              exp_lat;
        int              lat;
        bit              is_hit;
        is_hit  = model_hit(f3, a, b);
        exp_lat = is_hit ? 1 : LATENCY;
        got     = '0;
        check("in_ready_idle", 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1;
        bus.funct3   = f3;
        bus.a        = a;
        bus.b        = b;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        exp_q.push_back(ref_mul(f3, a, b));
        check("busy_after_accept", 64'(bus.busy), 64'd1);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!bus.out_valid) begin
            check("out_valid_timeout", 64'(bus.out_valid), 64'd1);
            void'(exp_q.pop_front());
            return;
        end
        check("latency", 64'(lat), 64'(exp_lat));
        e = exp_q.pop_front();
        check("result", 64'(bus.result), 64'(e));
        got = bus.result;
        if (!is_hit && f3 < 3'd4) begin
            mc_valid = 1'b1;
            mc_a     = a;
            mc_b     = b;
            mc_cls   = cls_of(f3);
        end
        for (int i = 0; i < stall; i++) begin
            bus.in_valid = 1'b1;
            bus.funct3   = f3 ^ 3'd1;
            bus.a        = a ^ 32'h1;
            @(posedge clk); #1;
            check("stall_out_valid", 64'(bus.out_valid), 64'd1);
            check("stall_result", 64'(bus.result), 64'(e));
            check("stall_in_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("post_hs_in_ready", 64'(bus.in_ready), 64'd1);
        check("post_hs_out_valid", 64'(bus.out_valid), 64'd0);
        check("post_hs_busy", 64'(bus.busy), 64'd0);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset    = 1'b0;
        mc_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [XLEN-1:0] got;
        logic [XLEN-1:0] ra;
        logic [XLEN-1:0] rb;
        logic [2:0]      rf;

        reset = 1'b1; flush = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.funct3 = 3'd0; bus.a = '0; bus.b = '0;
        apply_reset();
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_result", 64'(bus.result), 64'd0);

        // basic MUL
        do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0, got);
        check("mul_7_m3", 64'(got), 64'hFFFF_FFEB);

        // signedness
        do_op(3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 0, got);
        check("mulh_sign", 64'(got), 64'h0000_0000);
        do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, got);
        check("mulhsu_sign", 64'(got), 64'h8000_0000);
        do_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, got);
        check("mulhu_sign", 64'(got), 64'h7FFF_FFFF);

        // most-negative squared
        do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0, got);
        check("mulh_minmin", 64'(got), 64'h4000_0000);

        // stall 5 cycles with ignored requests
        do_op(3'd0, 32'd11, 32'd13, 5, got);
        check("stall_mul", 64'(got), 64'd143);
        @(posedge clk); #1;
        check("no_ghost_busy", 64'(bus.busy), 64'd0);

        // flush in IDLE with in_valid: request dropped
        flush = 1'b1; bus.in_valid = 1'b1; bus.funct3 = 3'd0; bus.a = 32'd3; bus.b = 32'd4;
        @(posedge clk); #1;
        flush = 1'b0; bus.in_valid = 1'b0;
        mc_valid = 1'b0;
        check("idle_flush_busy", 64'(bus.busy), 64'd0);
        check("idle_flush_in_ready", 64'(bus.in_ready), 64'd1);

        // flush at count==1
        bus.in_valid = 1'b1; bus.funct3 = 3'd0; bus.a = 32'd5; bus.b = 32'd9;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        mc_valid = 1'b0;
        check("flush_out_valid", 64'(bus.out_valid), 64'd0);
        check("flush_busy", 64'(bus.busy), 64'd0);
        check("flush_in_ready", 64'(bus.in_ready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("flush_no_result", 64'(bus.out_valid), 64'd0);
        end
        do_op(3'd0, 32'd2, 32'd3, 0, got);
        check("after_flush_mul", 64'(got), 64'd6);

        // cache reuse: MULH then MUL on the same operands
        do_op(3'd1, 32'h1234_5678, 32'h1234_5678, 0, got);
        check("cache_mulh", 64'(got), 64'h014B_66DC);
        do_op(3'd0, 32'h1234_5678, 32'h1234_5678, 0, got);
        check("cache_mul", 64'(got), 64'h1DF4_D840);

        // reserved funct3
        do_op(3'd5, 32'h1234_5678, 32'h9ABC_DEF0, 0, got);
        check("illegal_f3", 64'(got), 64'd0);

        // reset while BUSY
        bus.in_valid = 1'b1; bus.funct3 = 3'd3; bus.a = 32'hDEAD_BEEF; bus.b = 32'h1234;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        mc_valid = 1'b0;
        check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_result", 64'(bus.result), 64'd0);

        // randomized ops, with operand reuse to exercise the cache path
        ra = $urandom; rb = $urandom;
        for (int n = 0; n < 60; n++) begin
            rf = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 2) != 0) begin
                ra = $urandom;
                rb = $urandom;
            end
            do_op(rf, ra, rb, $urandom_range(0, 2), got);
        end

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
